x_req_arbiter: RTL and testbench

- Shares one memory request/response port between N_REQ x-vector caches, one per PE lane.
- Buffers each cache's uncontrolled request pulses in a per-requester queue and issues them to memory round-robin, tagged with the requester index.
- Routes tagged responses back to the owning cache and enforces a per-requester in-flight limit.
- Sits between the PE x-vector caches and the memory controller port.

---
 rtl/x_req_arbiter_pkg.sv | 20 ++
 rtl/x_req_arbiter_fifo.sv | 66 ++++++
 rtl/x_req_arbiter_rr.sv | 41 ++++
 rtl/x_req_arbiter.sv | 143 ++++++++++++++
 tb/tb_x_req_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/x_req_arbiter_pkg.sv
// Shared widths and helpers for the x-vector request arbiter slice.
package x_req_arbiter_pkg;

    localparam int ADDR_WIDTH = 48;
    localparam int DATA_WIDTH = 64;

    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    // floor(log2(value)); log2(n-1)+1 gives the bits needed to index n items.
    function automatic int log2(input int value);
        int result;
        result = 0;
        for (int v = value; v > 1; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/x_req_arbiter_fifo.sv
// Show-ahead request queue: the head entry is readable combinationally while non-empty.
module x_req_arbiter_fifo
    import x_req_arbiter_pkg::*;
#(
    parameter int WIDTH    = ADDR_WIDTH,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             almost_full,
    output logic             overflow
);

    localparam int PTR_W = log2(DEPTH - 1) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty       = (count_reg == '0);
    assign full        = (count_reg == (PTR_W+1)'(DEPTH));
    assign almost_full = (count_reg >= (PTR_W+1)'(AF_LEVEL));

    // A pop in the same cycle frees the slot, so a full queue still accepts the push.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && full && !do_pop;
    assign pop_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/x_req_arbiter_rr.sv
// Round-robin grant selection; searches from the index after the last grant.
module x_req_arbiter_rr
    import x_req_arbiter_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int LOG2_N_REQ = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      eligible,
    input  logic                  enable,
    output logic                  grant_valid,
    output logic [LOG2_N_REQ-1:0] grant_idx
);

    logic [LOG2_N_REQ-1:0] rr_ptr_reg;
    int                    cand;

    // Walk offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = (int'(rr_ptr_reg) + k) % N_REQ;
            if (enable && eligible[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = LOG2_N_REQ'(cand);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_reg <= LOG2_N_REQ'(N_REQ - 1);
        end else if (grant_valid) begin
            rr_ptr_reg <= grant_idx;
        end
    end

endmodule

// File: rtl/x_req_arbiter.sv
// Shares one memory port between N_REQ x-vector caches: queued round-robin issue,
// tagged response routing and a per-requester in-flight limit.
module x_req_arbiter
    import x_req_arbiter_pkg::*;
#(
    parameter int N_REQ             = 4,
    parameter int LOG2_N_REQ        = 2,
    parameter int REQ_FIFO_DEPTH    = 16,
    parameter int ALMOST_FULL_COUNT = 4,
    parameter int MAX_OUTSTANDING   = 512
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [ADDR_WIDTH*N_REQ-1:0] req_addr,
    output logic [N_REQ-1:0]            req_almost_full,
    output logic                        mem_req,
    output logic [ADDR_WIDTH-1:0]       mem_req_addr,
    output logic [LOG2_N_REQ-1:0]       mem_req_tag,
    input  logic                        mem_req_stall,
    input  logic                        mem_rsp_push,
    input  logic [LOG2_N_REQ-1:0]       mem_rsp_tag,
    input  logic [DATA_WIDTH-1:0]       mem_rsp_q,
    output logic [N_REQ-1:0]            rsp_push,
    output logic [DATA_WIDTH-1:0]       rsp_q,
    output logic                        overflow_err,
    output logic                        tag_err
);

    localparam int                 OUT_W     = log2(MAX_OUTSTANDING) + 1;
    localparam logic [OUT_W-1:0]   OUT_LIMIT = OUT_W'(MAX_OUTSTANDING);
    localparam int                 AF_LEVEL  = REQ_FIFO_DEPTH - ALMOST_FULL_COUNT;

    addr_t                 head [N_REQ];
    logic [N_REQ-1:0]      eligible;
    logic [N_REQ-1:0]      fifo_ovf;
    logic [N_REQ-1:0]      rsp_hit;
    logic                  rsp_tag_ok;
    logic                  grant_valid;
    logic [LOG2_N_REQ-1:0] grant_idx;

    logic                  mem_req_reg;
    addr_t                 mem_req_addr_reg;
    logic [LOG2_N_REQ-1:0] mem_req_tag_reg;
    logic [N_REQ-1:0]      rsp_push_reg;
    data_t                 rsp_q_reg;
    logic                  overflow_err_reg;
    logic                  tag_err_reg;

    // Out-of-range tags can only exist when N_REQ does not fill the tag space.
    generate
        if ((1 << LOG2_N_REQ) == N_REQ) begin : g_tag_full
            assign rsp_tag_ok = 1'b1;
        end else begin : g_tag_partial
            assign rsp_tag_ok = (int'(mem_rsp_tag) < N_REQ);
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            logic             grant_hit;
            logic             empty;
            logic [OUT_W-1:0] outstanding_reg;

            assign grant_hit   = grant_valid && (grant_idx == LOG2_N_REQ'(gi));
            assign rsp_hit[gi] = mem_rsp_push && rsp_tag_ok && (mem_rsp_tag == LOG2_N_REQ'(gi));
            assign eligible[gi] = !empty && (outstanding_reg < OUT_LIMIT);

            x_req_arbiter_fifo #(
                .WIDTH    (ADDR_WIDTH),
                .DEPTH    (REQ_FIFO_DEPTH),
                .AF_LEVEL (AF_LEVEL)
            ) u_fifo (
                .clk         (clk),
                .rst         (rst),
                .push        (req_valid[gi]),
                .push_data   (req_addr[ADDR_WIDTH*gi +: ADDR_WIDTH]),
                .pop         (grant_hit),
                .pop_data    (head[gi]),
                .empty       (empty),
                .almost_full (req_almost_full[gi]),
                .overflow    (fifo_ovf[gi])
            );

            // Responses for a requester with nothing in flight (e.g. after reset) leave it at 0.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    outstanding_reg <= '0;
                end else if (grant_hit && !rsp_hit[gi]) begin
                    outstanding_reg <= outstanding_reg + 1'b1;
                end else if (rsp_hit[gi] && !grant_hit && (outstanding_reg != '0)) begin
                    outstanding_reg <= outstanding_reg - 1'b1;
                end
            end
        end
    endgenerate

    x_req_arbiter_rr #(
        .N_REQ      (N_REQ),
        .LOG2_N_REQ (LOG2_N_REQ)
    ) u_rr (
        .clk         (clk),
        .rst         (rst),
        .eligible    (eligible),
        .enable      (!mem_req_stall),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_reg      <= 1'b0;
            mem_req_addr_reg <= '0;
            mem_req_tag_reg  <= '0;
            rsp_push_reg     <= '0;
            rsp_q_reg        <= '0;
            overflow_err_reg <= 1'b0;
            tag_err_reg      <= 1'b0;
        end else begin
            mem_req_reg <= grant_valid;
            if (grant_valid) begin
                mem_req_addr_reg <= head[grant_idx];
                mem_req_tag_reg  <= grant_idx;
            end
            rsp_push_reg <= rsp_hit;
            if (mem_rsp_push) begin
                rsp_q_reg <= mem_rsp_q;
            end
            overflow_err_reg <= overflow_err_reg | (|fifo_ovf);
            tag_err_reg      <= tag_err_reg | (mem_rsp_push && !rsp_tag_ok);
        end
    end

    assign mem_req      = mem_req_reg;
    assign mem_req_addr = mem_req_addr_reg;
    assign mem_req_tag  = mem_req_tag_reg;
    assign rsp_push     = rsp_push_reg;
    assign rsp_q        = rsp_q_reg;
    assign overflow_err = overflow_err_reg;
    assign tag_err      = tag_err_reg;

endmodule

// File: tb/tb_x_req_arbiter.sv
// Directed and randomized checks of x_req_arbiter against a queue-based reference model.
module tb_x_req_arbiter;

    localparam int N     = 4;
    localparam int LOGN  = 2;
    localparam int DEPTH = 16;
    localparam int AFC   = 4;
    localparam int MAXO  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [48*N-1:0] req_addr = '0;
    logic [N-1:0]    req_almost_full;
    logic            mem_req;
    logic [47:0]     mem_req_addr;
    logic [LOGN-1:0] mem_req_tag;
    logic            mem_req_stall = 1'b0;
    logic            mem_rsp_push = 1'b0;
    logic [LOGN-1:0] mem_rsp_tag = '0;
    logic [63:0]     mem_rsp_q = '0;
    logic [N-1:0]    rsp_push;
    logic [63:0]     rsp_q;
    logic            overflow_err;
    logic            tag_err;

    x_req_arbiter #(
        .N_REQ             (N),
        .LOG2_N_REQ        (LOGN),
        .REQ_FIFO_DEPTH    (DEPTH),
        .ALMOST_FULL_COUNT (AFC),
        .MAX_OUTSTANDING   (MAXO)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_almost_full (req_almost_full),
        .mem_req         (mem_req),
        .mem_req_addr    (mem_req_addr),
        .mem_req_tag     (mem_req_tag),
        .mem_req_stall   (mem_req_stall),
        .mem_rsp_push    (mem_rsp_push),
        .mem_rsp_tag     (mem_rsp_tag),
        .mem_rsp_q       (mem_rsp_q),
        .rsp_push        (rsp_push),
        .rsp_q           (rsp_q),
        .overflow_err    (overflow_err),
        .tag_err         (tag_err)
    );

    always #5 clk = ~clk;

    // Reference model: one address queue and one in-flight count per requester.
    logic [47:0]     mq [N][$];
    int              mout [N];
    int              mrr;
    logic            exp_mem_req;
    logic [47:0]     exp_addr;
    logic [LOGN-1:0] exp_tag;
    logic [N-1:0]    exp_rsp_push;
    logic [63:0]     exp_rsp_q;
    logic            exp_ovf;
    logic            exp_tagerr;

    int n_total = 0;
    int n_pass  = 0;
    int issued;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mq[i].delete();
            mout[i] = 0;
        end
        mrr          = N - 1;
        exp_mem_req  = 1'b0;
        exp_addr     = '0;
        exp_tag      = '0;
        exp_rsp_push = '0;
        exp_rsp_q    = '0;
        exp_ovf      = 1'b0;
        exp_tagerr   = 1'b0;
    endtask

    task automatic model_edge();
        int g;
        g = -1;
        if (!mem_req_stall) begin
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (mrr + k) % N;
                if (g < 0 && mq[c].size() > 0 && mout[c] < MAXO) g = c;
            end
        end
        exp_mem_req = (g >= 0);
        if (g >= 0) begin
            exp_addr = mq[g].pop_front();
            exp_tag  = LOGN'(g);
            mrr      = g;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                if (mq[i].size() < DEPTH) mq[i].push_back(req_addr[48*i +: 48]);
                else exp_ovf = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            bit inc, dec;
            inc = (g == i);
            dec = mem_rsp_push && (int'(mem_rsp_tag) == i);
            if (inc && !dec) mout[i]++;
            else if (dec && !inc && mout[i] > 0) mout[i]--;
        end
        exp_rsp_push = '0;
        if (mem_rsp_push) begin
            exp_rsp_push[mem_rsp_tag] = 1'b1;
            exp_rsp_q = mem_rsp_q;
        end
    endtask

    task automatic check_outputs();
        logic [N-1:0] exp_af;
        for (int i = 0; i < N; i++) exp_af[i] = (mq[i].size() >= DEPTH - AFC);
        check("mem_req", mem_req, exp_mem_req);
        check("mem_req_addr", mem_req_addr, exp_addr);
        check("mem_req_tag", mem_req_tag, exp_tag);
        check("rsp_push", rsp_push, exp_rsp_push);
        check("rsp_q", rsp_q, exp_rsp_q);
        check("req_almost_full", req_almost_full, exp_af);
        check("overflow_err", overflow_err, exp_ovf);
        check("tag_err", tag_err, exp_tagerr);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_outputs();
        if (mem_req) issued++;
    endtask

    task automatic respond(input int tag, input int times);
        for (int n = 0; n < times; n++) begin
            mem_rsp_push = 1'b1;
            mem_rsp_tag  = LOGN'(tag);
            mem_rsp_q    = {$urandom, $urandom};
            tick();
        end
        mem_rsp_push = 1'b0;
    endtask

    initial begin
        // Reset state
        model_reset();
        #1;
        check_outputs();
        tick();
        tick();
        @(negedge clk);
        rst = 1'b0;

        // Fairness: all four push 3 addresses in the same cycles
        for (int t = 0; t < 13; t++) begin
            if (t < 3) begin
                req_valid = '1;
                for (int i = 0; i < N; i++) req_addr[48*i +: 48] = 48'h2000 + 48'(i * 256 + t * 8);
            end else begin
                req_valid = '0;
            end
            tick();
            if (t >= 1) begin
                check("fair_req", mem_req, 1);
                check("fair_tag", mem_req_tag, (t - 1) % 4);
            end
        end
        for (int i = 0; i < N; i++) respond(i, 3);

        // Single request from requester 2, then its response
        req_valid = 4'b0100;
        req_addr[48*2 +: 48] = 48'h1000;
        tick();
        req_valid = '0;
        check("single_early", mem_req, 0);
        tick();
        check("single_req", mem_req, 1);
        check("single_addr", mem_req_addr, 48'h1000);
        check("single_tag", mem_req_tag, 2);
        mem_rsp_push = 1'b1;
        mem_rsp_tag  = 2'd2;
        mem_rsp_q    = 64'hDEAD;
        tick();
        mem_rsp_push = 1'b0;
        check("single_rsp_push", rsp_push, 4'b0100);
        check("single_rsp_q", rsp_q, 64'hDEAD);
        tick();
        check("single_rsp_clear", rsp_push, 4'b0000);

        // Stall for 10 cycles with all queues loaded
        mem_req_stall = 1'b1;
        for (int t = 0; t < 10; t++) begin
            req_valid = (t < 2) ? 4'b1111 : 4'b0000;
            for (int i = 0; i < N; i++) req_addr[48*i +: 48] = 48'h3000 + 48'(i * 256 + t * 8);
            tick();
            check("stall_quiet", mem_req, 0);
        end
        req_valid = '0;
        mem_req_stall = 1'b0;
        issued = 0;
        tick();
        check("stall_resume", mem_req, 1);
        for (int t = 0; t < 10; t++) tick();
        check("stall_issued", issued, 8);
        for (int i = 0; i < N; i++) respond(i, 2);

        // In-flight limit on requester 0
        issued = 0;
        for (int t = 0; t < 16; t++) begin
            req_valid = (t < 6) ? 4'b0001 : 4'b0000;
            req_addr[47:0] = 48'h4000 + 48'(t * 8);
            tick();
        end
        req_valid = '0;
        check("limit_issued", issued, 4);
        issued = 0;
        respond(0, 1);
        for (int t = 0; t < 5; t++) tick();
        check("limit_one_more", issued, 1);
        respond(0, 5);

        // Overflow and almost-full on requester 1
        mem_req_stall = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            req_valid = 4'b0010;
            req_addr[48*1 +: 48] = 48'h5000 + 48'(k * 8);
            tick();
            check("af_level", req_almost_full[1], (k >= 12));
            check("ovf_level", overflow_err, (k >= 17));
        end
        req_valid = '0;
        mem_req_stall = 1'b0;
        issued = 0;
        mem_rsp_push = 1'b1;
        mem_rsp_tag  = 2'd1;
        for (int t = 0; t < 40; t++) begin
            mem_rsp_q = 64'(t);
            tick();
        end
        mem_rsp_push = 1'b0;
        check("ovf_issued", issued, 16);

        // Asynchronous reset in the middle of traffic
        for (int t = 0; t < 3; t++) begin
            req_valid = 4'b1111;
            for (int i = 0; i < N; i++) req_addr[48*i +: 48] = 48'h6000 + 48'(i * 256 + t * 8);
            tick();
        end
        @(negedge clk);
        req_valid = '0;
        rst = 1'b1;
        #1;
        check("arst_mem_req", mem_req, 0);
        check("arst_addr", mem_req_addr, 0);
        check("arst_tag", mem_req_tag, 0);
        check("arst_rsp_q", rsp_q, 0);
        check("arst_ovf", overflow_err, 0);
        check("arst_af", req_almost_full, 0);
        model_reset();
        tick();
        @(negedge clk);
        rst = 1'b0;
        mem_rsp_push = 1'b1;
        mem_rsp_tag  = 2'd3;
        mem_rsp_q    = 64'hBEEF;
        tick();
        mem_rsp_push = 1'b0;
        check("post_rst_rsp", rsp_push, 4'b1000);
        issued = 0;
        for (int t = 0; t < 15; t++) begin
            req_valid = (t < 5) ? 4'b1000 : 4'b0000;
            req_addr[48*3 +: 48] = 48'h7000 + 48'(t * 8);
            tick();
        end
        req_valid = '0;
        check("post_rst_limit", issued, 4);

        // Randomized traffic
        for (int t = 0; t < 1500; t++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 99) < 25);
                req_addr[48*i +: 48] = {$urandom, $urandom};
            end
            mem_req_stall = ($urandom_range(0, 99) < 20);
            mem_rsp_push  = ($urandom_range(0, 99) < 40);
            mem_rsp_tag   = LOGN'($urandom_range(0, N - 1));
            mem_rsp_q     = {$urandom, $urandom};
            tick();
        end
        req_valid = '0;
        mem_req_stall = 1'b0;
        mem_rsp_push = 1'b0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
